// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 register bank, inputs synchronised into clk.
// Define SPI_REG_BANK_READBACK_EN to return register data on CIPO.
module spi_reg_bank #(
   parameter int NUM_REGS    = 5,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       spi_sclk,
   input  logic                       spi_copi,
   input  logic                       spi_ncs,
   output logic                       spi_cipo,
   output logic                       spi_cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       frame_err
);

   localparam int F  = 1 + ADDR_W + DATA_W;
   localparam int CW = $clog2(F + 2);
   localparam logic [CW-1:0]   CNT_F   = CW'(F);
   localparam logic [CW-1:0]   CNT_SAT = CW'(F + 1);
   localparam logic [ADDR_W:0] NREG    = (ADDR_W + 1)'(NUM_REGS);

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q, vld;
   logic sclk_d, ncs_d, armed;
   logic sclk_s, copi_s, ncs_s;
   logic sclk_rise, ncs_rise, ncs_fall;

   logic [CW-1:0]     cnt;
   logic [F-1:0]      shreg;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              frame_ok, is_wr, in_rng, do_wr, do_err;

   assign sclk_s = sclk_q[SYNC_STAGES-1];
   assign copi_s = copi_q[SYNC_STAGES-1];
   assign ncs_s  = ncs_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign ncs_rise  = ncs_s & ~ncs_d;
   // A low nCS seen right after reset is not a fresh frame start.
   assign ncs_fall  = armed & ~ncs_s & ncs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_q <= '0;
         copi_q <= '0;
         ncs_q  <= '1;
         vld    <= '0;
         sclk_d <= 1'b0;
         ncs_d  <= 1'b1;
         armed  <= 1'b0;
      end else begin
         sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
         copi_q <= {copi_q[SYNC_STAGES-2:0], spi_copi};
         ncs_q  <= {ncs_q[SYNC_STAGES-2:0], spi_ncs};
         vld    <= {vld[SYNC_STAGES-2:0], 1'b1};
         sclk_d <= sclk_s;
         ncs_d  <= ncs_s;
         armed  <= armed | (vld[SYNC_STAGES-1] & ncs_s);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ncs_fall) state_nx = SHIFT;
         SHIFT:   if (ncs_rise) state_nx = COMMIT;
         COMMIT:  state_nx = ncs_fall ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign is_wr    = shreg[F-1];
   assign addr     = shreg[DATA_W +: ADDR_W];
   assign data     = shreg[DATA_W-1:0];
   assign frame_ok = (cnt == CNT_F);
   assign in_rng   = ({1'b0, addr} < NREG);
   assign do_wr    = (state == COMMIT) & frame_ok & is_wr & in_rng;
   assign do_err   = (state == COMMIT) & ~frame_ok;

   // Bit counted in the same cycle nCS rises still belongs to the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (ncs_fall && state != SHIFT) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (state == SHIFT && sclk_rise) begin
         shreg <= {shreg[F-2:0], copi_s};
         if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_flat <= '0;
         wr_strobe <= '0;
         frame_err <= 1'b0;
      end else begin
         wr_strobe <= '0;
         frame_err <= do_err;
         if (do_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (addr == ADDR_W'(i)) begin
                  regs_flat[i*DATA_W +: DATA_W] <= data;
                  wr_strobe[i] <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SPI_REG_BANK_READBACK_EN
   localparam logic [CW-1:0] CNT_A = CW'(1 + ADDR_W);

   logic              sclk_fall, rd_oe;
   logic [DATA_W-1:0] rd_sh, rd_data;

   assign sclk_fall = ~sclk_s & sclk_d;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (shreg[ADDR_W-1:0] == ADDR_W'(i))
            rd_data = regs_flat[i*DATA_W +: DATA_W];
      end
   end

   // Latch on the fall after the last address bit; shift on later falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_oe <= 1'b0;
         rd_sh <= '0;
      end else if (state != SHIFT || ncs_rise) begin
         rd_oe <= 1'b0;
         rd_sh <= '0;
      end else if (sclk_fall) begin
         if (!rd_oe && cnt == CNT_A && !shreg[ADDR_W]) begin
            rd_oe <= 1'b1;
            rd_sh <= rd_data;
         end else if (rd_oe) begin
            rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign spi_cipo    = rd_sh[DATA_W-1];
   assign spi_cipo_oe = rd_oe;
`else
   assign spi_cipo    = 1'b0;
   assign spi_cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed SPI frames against two spi_reg_bank builds.
// Readback checks run only when SPI_REG_BANK_READBACK_EN is defined.
module tb_spi_reg_bank;

   localparam int HP = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sclk = 1'b0;
   logic copi = 1'b0;
   logic ncs0 = 1'b1;
   logic ncs1 = 1'b1;

   logic         cipo0, oe0, err0;
   logic [39:0]  regs0;
   logic [4:0]   stb0;
   logic         cipo1, oe1, err1;
   logic [127:0] regs1;
   logic [7:0]   stb1;

   int checks = 0;
   int failures = 0;
   int stb_hi, stb_at, err_hi, err_at;
   logic [7:0] stb_or;

   always #5 clk = ~clk;

   spi_reg_bank dut0 (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(sclk), .spi_copi(copi), .spi_ncs(ncs0),
      .spi_cipo(cipo0), .spi_cipo_oe(oe0),
      .regs_flat(regs0), .wr_strobe(stb0), .frame_err(err0)
   );

   spi_reg_bank #(
      .NUM_REGS(8), .ADDR_W(3), .DATA_W(16), .SYNC_STAGES(2)
   ) dut1 (
      .clk(clk), .rst_n(rst_n),
      .spi_sclk(sclk), .spi_copi(copi), .spi_ncs(ncs1),
      .spi_cipo(cipo1), .spi_cipo_oe(oe1),
      .regs_flat(regs1), .wr_strobe(stb1), .frame_err(err1)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ncs(input bit dev, input logic v);
      if (dev) ncs1 = v;
      else     ncs0 = v;
   endtask

   task automatic frame_start(input bit dev);
      set_ncs(dev, 1'b0);
      cyc(HP);
   endtask

   task automatic send_bit(input logic b);
      copi = b;
      cyc(HP);
      sclk = 1'b1;
      cyc(HP);
      sclk = 1'b0;
   endtask

   // Raise nCS and record strobe/error activity for the following cycles.
   task automatic frame_end(input bit dev);
      logic [7:0] s;
      logic e;
      cyc(HP);
      set_ncs(dev, 1'b1);
      stb_or = '0;
      stb_hi = 0; stb_at = 0;
      err_hi = 0; err_at = 0;
      for (int k = 1; k <= 8; k++) begin
         cyc(1);
         s = dev ? stb1 : {3'b000, stb0};
         e = dev ? err1 : err0;
         if (s != 8'h00) begin
            stb_or = stb_or | s;
            stb_hi++;
            stb_at = k;
         end
         if (e) begin
            err_hi++;
            err_at = k;
         end
      end
   endtask

   task automatic spi_frame(input logic [31:0] v, input int n,
                            input bit dev);
      frame_start(dev);
      for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
      frame_end(dev);
   endtask

   task automatic test_reset;
      cyc(2);
      checks++;
      if (regs0 !== 40'h0) begin
         failures++;
         $display("FAIL reset_regs0: got %h expected 0", regs0);
      end
      checks++;
      if (regs1 !== 128'h0) begin
         failures++;
         $display("FAIL reset_regs1: got %h expected 0", regs1);
      end
      checks++;
      if (stb0 !== 5'h0 || err0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses: got stb=%b err=%b expected 0 0",
                  stb0, err0);
      end
      checks++;
      if (cipo0 !== 1'b0 || oe0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_cipo: got cipo=%b oe=%b expected 0 0",
                  cipo0, oe0);
      end
      rst_n = 1'b1;
      cyc(6);
   endtask

   task automatic test_write;
      spi_frame(32'h80F0, 16, 1'b0);
      checks++;
      if (regs0 !== 40'h00_00_00_00_F0) begin
         failures++;
         $display("FAIL write_reg0: got %h expected 00000000f0", regs0);
      end
      checks++;
      if (stb_or !== 8'h01 || stb_hi != 1) begin
         failures++;
         $display("FAIL write_strobe: got %b x%0d expected 00000001 x1",
                  stb_or, stb_hi);
      end
      checks++;
      if (stb_at != 4) begin
         failures++;
         $display("FAIL write_latency: got %0d expected 4", stb_at);
      end
      checks++;
      if (err_hi != 0) begin
         failures++;
         $display("FAIL write_noerr: got %0d expected 0", err_hi);
      end
   endtask

   task automatic test_range;
      spi_frame(32'h8480, 16, 1'b0);
      checks++;
      if (regs0 !== 40'h80_00_00_00_F0 || stb_or !== 8'h10) begin
         failures++;
         $display("FAIL range_reg4: got %h stb=%b expected 80000000f0 10000",
                  regs0, stb_or);
      end
      spi_frame(32'h85AA, 16, 1'b0);
      checks++;
      if (regs0 !== 40'h80_00_00_00_F0) begin
         failures++;
         $display("FAIL range_oob_regs: got %h expected 80000000f0", regs0);
      end
      checks++;
      if (stb_hi != 0 || err_hi != 0) begin
         failures++;
         $display("FAIL range_oob_pulses: got stb=%0d err=%0d expected 0 0",
                  stb_hi, err_hi);
      end
   endtask

   task automatic test_frame_err;
      spi_frame(32'h811, 12, 1'b0);
      checks++;
      if (err_hi != 1 || err_at != 4) begin
         failures++;
         $display("FAIL err_short: got %0d@%0d expected 1@4", err_hi, err_at);
      end
      checks++;
      if (stb_hi != 0) begin
         failures++;
         $display("FAIL err_short_stb: got %0d expected 0", stb_hi);
      end
      spi_frame(32'h10223, 17, 1'b0);
      checks++;
      if (err_hi != 1) begin
         failures++;
         $display("FAIL err_long: got %0d expected 1", err_hi);
      end
      checks++;
      if (regs0 !== 40'h80_00_00_00_F0) begin
         failures++;
         $display("FAIL err_regs: got %h expected 80000000f0", regs0);
      end
      spi_frame(32'h0100, 15, 1'b0);
      checks++;
      if (err_hi != 1) begin
         failures++;
         $display("FAIL err_short_read: got %0d expected 1", err_hi);
      end
      spi_frame(32'h0000, 16, 1'b0);
      checks++;
      if (err_hi != 0 || stb_hi != 0) begin
         failures++;
         $display("FAIL read_full: got err=%0d stb=%0d expected 0 0",
                  err_hi, stb_hi);
      end
   endtask

`ifdef SPI_REG_BANK_READBACK_EN
   task automatic test_readback;
      logic [15:0] rd;
      logic [7:0] exp;
      rd = 16'h0200;
      exp = 8'h5A;
      spi_frame(32'h825A, 16, 1'b0);
      checks++;
      if (regs0[23:16] !== 8'h5A) begin
         failures++;
         $display("FAIL rb_write: got %h expected 5a", regs0[23:16]);
      end
      frame_start(1'b0);
      for (int i = 15; i >= 0; i--) begin
         copi = rd[i];
         cyc(HP);
         checks++;
         if (oe0 !== 1'(i < 8)) begin
            failures++;
            $display("FAIL rb_oe bit %0d: got %b expected %b",
                     i, oe0, 1'(i < 8));
         end
         if (i < 8) begin
            checks++;
            if (cipo0 !== exp[i]) begin
               failures++;
               $display("FAIL rb_cipo bit %0d: got %b expected %b",
                        i, cipo0, exp[i]);
            end
         end
         sclk = 1'b1;
         cyc(HP);
         sclk = 1'b0;
      end
      frame_end(1'b0);
      checks++;
      if (oe0 !== 1'b0 || err_hi != 0) begin
         failures++;
         $display("FAIL rb_end: got oe=%b err=%0d expected 0 0", oe0, err_hi);
      end
   endtask
`endif

   task automatic test_reset_mid_frame;
      logic [15:0] v;
      v = 16'h8144;
      spi_frame(32'h8133, 16, 1'b0);
      checks++;
      if (regs0[15:8] !== 8'h33) begin
         failures++;
         $display("FAIL mid_pre: got %h expected 33", regs0[15:8]);
      end
      frame_start(1'b0);
      for (int i = 15; i >= 7; i--) send_bit(v[i]);
      rst_n = 1'b0;
      cyc(3);
      checks++;
      if (regs0 !== 40'h0 || stb0 !== 5'h0) begin
         failures++;
         $display("FAIL mid_reset: got %h stb=%b expected 0 0", regs0, stb0);
      end
      rst_n = 1'b1;
      cyc(10);
      frame_end(1'b0);
      checks++;
      if (err_hi != 0 || stb_hi != 0) begin
         failures++;
         $display("FAIL mid_discard: got err=%0d stb=%0d expected 0 0",
                  err_hi, stb_hi);
      end
      spi_frame(32'h8155, 16, 1'b0);
      checks++;
      if (regs0 !== 40'h00_00_00_55_00 || stb_or !== 8'h02) begin
         failures++;
         $display("FAIL mid_next: got %h stb=%b expected 0000005500 00010",
                  regs0, stb_or);
      end
   endtask

   task automatic test_params;
      spi_frame(32'hFBEEF, 20, 1'b1);
      checks++;
      if (regs1[127:112] !== 16'hBEEF) begin
         failures++;
         $display("FAIL p_reg7: got %h expected beef", regs1[127:112]);
      end
      checks++;
      if (regs1[111:0] !== 112'h0) begin
         failures++;
         $display("FAIL p_others: got %h expected 0", regs1[111:0]);
      end
      checks++;
      if (stb_or !== 8'h80 || err_hi != 0) begin
         failures++;
         $display("FAIL p_strobe: got %b err=%0d expected 10000000 0",
                  stb_or, err_hi);
      end
   endtask

   task automatic test_back_to_back;
      spi_frame(32'h833C, 16, 1'b0);
      checks++;
      if (stb_or !== 8'h08) begin
         failures++;
         $display("FAIL b2b_first: got %b expected 01000", stb_or);
      end
      spi_frame(32'h82C3, 16, 1'b0);
      checks++;
      if (regs0 !== 40'h00_3C_C3_55_00 || stb_or !== 8'h04) begin
         failures++;
         $display("FAIL b2b_second: got %h stb=%b expected 003cc35500 00100",
                  regs0, stb_or);
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_range;
      test_frame_err;
`ifdef SPI_REG_BANK_READBACK_EN
      test_readback;
`endif
      test_reset_mid_frame;
      test_params;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI mode-0 register bank that supersedes the fixed five-register write-only SPI peripheral. It synchronises SCLK/COPI/nCS into the `clk` domain and decodes frames of 1 R/W bit, ADDR_W address bits and DATA_W data bits. It commits writes into NUM_REGS registers only on a complete, exact-length frame, and optionally returns register contents on CIPO. It sits between the chip-level SPI pins and the output-enable/PWM configuration logic.

## Interface
- NUM_REGS, 5: number of implemented registers, 1..2^ADDR_W.
- ADDR_W, 7: address field width.
- DATA_W, 8: register and data field width.
- SYNC_STAGES, 2: synchroniser flops per SPI input, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock, idle low (mode 0).
- spi_copi  in  1  serial data in, MSB first.
- spi_ncs  in  1  chip select, active low.
- spi_cipo  out  1  serial data out (0 when unused).
- spi_cipo_oe  out  1  CIPO drive enable, high while nCS is low and a read frame is active.
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  NUM_REGS  one-cycle pulse on the committed register.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Frame length is F = 1+ADDR_W+DATA_W bits. Bit 0 is R/W (1 = write), then address MSB first, then data MSB first.
- Sampling:
  - COPI is sampled on each synchronised SCLK rising edge while synchronised nCS is low.
  - The bit counter saturates at F+1.
- States:
  - IDLE → SHIFT on nCS falling edge. The bit counter and shift register clear.
  - SHIFT → COMMIT on nCS rising edge.
  - COMMIT → IDLE after one cycle.
- Commit rules:
  - A write with count == F and addr < NUM_REGS updates register[addr] and pulses wr_strobe[addr].
  - A write with count == F and addr ≥ NUM_REGS is ignored silently, with no strobe and no error.
  - A frame with count ≠ F (short or long), read or write, pulses frame_err. No register changes.
  - A read with count == F changes nothing and produces no error.
- SCLK edges while nCS is high are ignored.
- An SCLK rising edge and an nCS rising edge detected in the same cycle: the bit is counted first, then the frame is evaluated.
- Reset:
  - All registers, regs_flat, wr_strobe, frame_err, spi_cipo and spi_cipo_oe go to 0. The FSM goes to IDLE.
  - Synchronisers reset to SCLK=0, COPI=0, nCS=1.
  - Reset mid-frame discards the frame. The next frame needs a fresh nCS falling edge.
- Out-of-range read address returns all-zero data.

## Timing
- Input-to-internal latency: SYNC_STAGES clk for synchronisation plus 1 clk for edge detection.
- SPI constraints: SCLK high and low phases each ≥ SYNC_STAGES+3 clk periods. nCS setup to first SCLK rise and hold after last SCLK fall are each ≥ SYNC_STAGES+3 clk.
- Write commit: register value and wr_strobe change on the same clk edge, SYNC_STAGES+2 clk after spi_ncs rises.
- frame_err asserts on the same relative cycle as a commit would.
- wr_strobe and frame_err are high for exactly 1 clk.
- Back-to-back frames: nCS high time ≥ SYNC_STAGES+3 clk. A new frame may start while COMMIT is in progress.

## Configuration
- Macro: SPI_REG_BANK_READBACK_EN.
- Defined:
  - When the R/W bit is 0, the block latches register[addr] on the synchronised SCLK falling edge after the last address bit.
  - spi_cipo then presents data MSB first, changing on each following SCLK falling edge.
  - spi_cipo_oe is high from that latch until nCS rises.
- Undefined: spi_cipo and spi_cipo_oe are tied to 0. Reads are still length-checked for frame_err.

## Test plan
- Write 0x80F0, i.e. R/W=1, addr 0x00, data 0xF0 (defaults) → reg0 = 0xF0, wr_strobe = 5'b00001 for 1 clk, frame_err stays 0.
- Write addr 0x04 data 0x80, then write addr 0x05 data 0xAA → reg4 = 0x80, no other register changes, no strobe for addr 0x05.
- Write frame truncated to 12 bits, then 17-bit frame → frame_err pulses twice, all registers unchanged.
- With readback enabled: write reg2 = 0x5A, then read frame 0x0200 → CIPO shifts 0x5A over the 8 data bits, cipo_oe high only during those bits.
- Assert rst_n low after 9 bits of a write to reg1 holding 0x33 → reg1 = 0x00. The next full frame commits normally.
- Parameters NUM_REGS=8, ADDR_W=3, DATA_W=16: write reg7 = 0xBEEF with a 20-bit frame → regs_flat[127:112] = 0xBEEF.
